// File: rtl/aes_gcm_pkg.sv
// Shared types and helpers for the AES-256-GCM message sequencer and its GHASH multiplier.
package aes_gcm_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HKEY,
        S_TMASK,
        S_AAD,
        S_CTR,
        S_TXT,
        S_LEN,
        S_FIN
    } state_e;

    localparam logic [31:0]  J0_LSW    = 32'd1;
    localparam int           LEN_SHIFT = 7;
    // GF(2^128) reduction constant in GCM's bit-reflected representation.
    localparam logic [127:0] GHASH_R   = {8'he1, 120'd0};

    // Increment only the low 32-bit word; it wraps without carrying into the nonce.
    function automatic logic [127:0] inc32(input logic [127:0] x);
        return {x[127:32], x[31:0] + 32'd1};
    endfunction

endpackage

// File: rtl/aes_gcm_seq_ghash.sv
// Combinational GHASH step: y_out = (y_prev ^ data_in) * h_key in GF(2^128).
// Zero latency, no flow control; the caller decides when to register the result.
module aes_gcm_seq_ghash
    import aes_gcm_pkg::*;
(
    input  logic [127:0] data_in,
    input  logic [127:0] h_key,
    input  logic [127:0] y_prev,
    output logic [127:0] y_out
);

    logic [127:0] x_s;
    logic [127:0] z_s;
    logic [127:0] v_s;

    // Bit 127 is the x^0 coefficient, so the multiplier walks MSB first and shifts V right.
    always_comb begin
        x_s = y_prev ^ data_in;
        z_s = '0;
        v_s = h_key;
        for (int i = 0; i < 128; i++) begin
            if (x_s[127-i]) begin
                z_s = z_s ^ v_s;
            end
            v_s = v_s[0] ? ((v_s >> 1) ^ GHASH_R) : (v_s >> 1);
        end
    end

    assign y_out = z_s;

endmodule

// File: rtl/aes_gcm_seq.sv
// AES-256-GCM message sequencer over a shared iterative AES core; one text block per AES latency + 1 cycle.
// Input stalls while AES is busy or the 1-entry output register is full; LEN waits for the output to drain.
module aes_gcm_seq
    import aes_gcm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             decrypt,
    input  logic [255:0]     key,
    input  logic [95:0]      nonce,
    input  logic [CNT_W-1:0] aad_blks,
    input  logic [CNT_W-1:0] txt_blks,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic [127:0]     din_data,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [127:0]     dout_data,
    output logic             aes_req,
    output logic [127:0]     aes_in,
    input  logic             aes_ack,
    input  logic [127:0]     aes_out,
    output logic             busy,
    output logic             done,
    output logic [127:0]     tag_out
);

    state_e             state_q, state_d;
    logic [127:0]       h_q, h_d, mask_q, mask_d, ks_q, ks_d;
    logic [127:0]       ctr_q, ctr_d, y_q, y_d;
    logic [127:0]       dout_data_q, dout_data_d, tag_q, tag_d;
    logic [95:0]        nonce_q, nonce_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, aad_blks_q, aad_blks_d, txt_blks_q, txt_blks_d;
    logic               decrypt_q, decrypt_d, dout_valid_q, dout_valid_d;
    logic               done_q, done_d, busy_q, busy_d;

    logic [CNT_W-1:0]   cnt_inc;
    logic [127:0]       gh_in, gh_out, txt_ct, len_blk;
    logic               din_acc;

    // The key is consumed by the external AES core, not by this sequencer.
    logic               key_unused;
    assign key_unused = ^key;

    assign din_ready  = (state_q == S_AAD) ||
                        ((state_q == S_TXT) && (!dout_valid_q || dout_ready));
    assign din_acc    = din_valid && din_ready;
    assign cnt_inc    = cnt_q + CNT_W'(1);
    assign txt_ct     = decrypt_q ? din_data : (din_data ^ ks_q);
    assign len_blk    = {64'(aad_blks_q) << LEN_SHIFT, 64'(txt_blks_q) << LEN_SHIFT};

    assign aes_req    = (state_q == S_HKEY) || (state_q == S_TMASK) || (state_q == S_CTR);
    assign dout_valid = dout_valid_q;
    assign dout_data  = dout_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign tag_out    = tag_q;

    always_comb begin
        case (state_q)
            S_TMASK: aes_in = {nonce_q, J0_LSW};
            S_CTR:   aes_in = ctr_q;
            default: aes_in = '0;
        endcase
    end

    always_comb begin
        case (state_q)
            S_AAD:   gh_in = din_data;
            S_TXT:   gh_in = txt_ct;
            default: gh_in = len_blk;
        endcase
    end

    aes_gcm_seq_ghash u_ghash (
        .data_in (gh_in),
        .h_key   (h_q),
        .y_prev  (y_q),
        .y_out   (gh_out)
    );

    always_comb begin
        state_d      = state_q;
        h_d          = h_q;
        mask_d       = mask_q;
        ks_d         = ks_q;
        ctr_d        = ctr_q;
        y_d          = y_q;
        dout_data_d  = dout_data_q;
        tag_d        = tag_q;
        nonce_d      = nonce_q;
        cnt_d        = cnt_q;
        aad_blks_d   = aad_blks_q;
        txt_blks_d   = txt_blks_q;
        decrypt_d    = decrypt_q;
        dout_valid_d = dout_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        // Drain first so a same-cycle accept in TXT refills the register without a bubble.
        if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    decrypt_d  = decrypt;
                    nonce_d    = nonce;
                    aad_blks_d = aad_blks;
                    txt_blks_d = txt_blks;
                    cnt_d      = '0;
                    y_d        = '0;
                    busy_d     = 1'b1;
                    state_d    = S_HKEY;
                end
            end
            S_HKEY: begin
                if (aes_ack) begin
                    h_d     = aes_out;
                    state_d = S_TMASK;
                end
            end
            S_TMASK: begin
                if (aes_ack) begin
                    mask_d  = aes_out;
                    ctr_d   = inc32({nonce_q, J0_LSW});
                    state_d = (aad_blks_q != '0) ? S_AAD :
                              (txt_blks_q != '0) ? S_CTR : S_LEN;
                end
            end
            S_AAD: begin
                if (din_acc) begin
                    y_d   = gh_out;
                    cnt_d = cnt_inc;
                    if (cnt_inc == aad_blks_q) begin
                        cnt_d   = '0;
                        state_d = (txt_blks_q != '0) ? S_CTR : S_LEN;
                    end
                end
            end
            S_CTR: begin
                if (aes_ack) begin
                    ks_d    = aes_out;
                    ctr_d   = inc32(ctr_q);
                    state_d = S_TXT;
                end
            end
            S_TXT: begin
                if (din_acc) begin
                    dout_data_d  = din_data ^ ks_q;
                    dout_valid_d = 1'b1;
                    y_d          = gh_out;
                    cnt_d        = cnt_inc;
                    state_d      = (cnt_inc == txt_blks_q) ? S_LEN : S_CTR;
                end
            end
            S_LEN: begin
                if (!dout_valid_q) begin
                    y_d     = gh_out;
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                tag_d   = y_q ^ mask_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            h_q          <= '0;
            mask_q       <= '0;
            ks_q         <= '0;
            ctr_q        <= '0;
            y_q          <= '0;
            dout_data_q  <= '0;
            tag_q        <= '0;
            nonce_q      <= '0;
            cnt_q        <= '0;
            aad_blks_q   <= '0;
            txt_blks_q   <= '0;
            decrypt_q    <= 1'b0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            h_q          <= h_d;
            mask_q       <= mask_d;
            ks_q         <= ks_d;
            ctr_q        <= ctr_d;
            y_q          <= y_d;
            dout_data_q  <= dout_data_d;
            tag_q        <= tag_d;
            nonce_q      <= nonce_d;
            cnt_q        <= cnt_d;
            aad_blks_q   <= aad_blks_d;
            txt_blks_q   <= txt_blks_d;
            decrypt_q    <= decrypt_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_aes_gcm_seq.sv
// Directed bench for aes_gcm_seq with a behavioural AES-256 core answering after 1..20 cycles.
module tb_aes_gcm_seq;

    localparam logic [127:0] C_TC14   = 128'hcea7403d4d606b6e074ec5d3baf39d18;
    localparam logic [127:0] TAG_TC13 = 128'h530f8afbc74536b9a963b4f1c4cb738b;
    localparam logic [127:0] TAG_TC14 = 128'hd0d1c8a799996bf0265b98b5d48ab919;

    logic          clk, rst, start, decrypt;
    logic [255:0]  key;
    logic [95:0]   nonce;
    logic [15:0]   aad_blks, txt_blks;
    logic          din_valid, din_ready, dout_valid, dout_ready;
    logic [127:0]  din_data, dout_data, aes_in, aes_out, tag_out;
    logic          aes_req, aes_ack, busy, done;

    logic          resp_ack, inj_ack, fixed_dly, stall_en;
    logic [127:0]  resp_out, inj_out;
    assign aes_ack = resp_ack | inj_ack;
    assign aes_out = inj_ack ? inj_out : resp_out;

    int            n_vec, n_err;
    logic [127:0]  req_log [$];
    logic [127:0]  out_q [$];
    logic [127:0]  blk [16];
    logic [127:0]  exp_out [16];
    logic [127:0]  exp_tag;
    logic [7:0]    sbox_t [256];

    aes_gcm_seq #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .key(key), .nonce(nonce),
        .aad_blks(aad_blks), .txt_blks(txt_blks), .din_valid(din_valid), .din_ready(din_ready),
        .din_data(din_data), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
        .aes_req(aes_req), .aes_in(aes_in), .aes_ack(aes_ack), .aes_out(aes_out),
        .busy(busy), .done(done), .tag_out(tag_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- AES-256 / GHASH reference ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = xt(a);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul8(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    function automatic logic [127:0] aes_encr(input logic [255:0] k, input logic [127:0] pt);
        logic [31:0]  w [60];
        logic [31:0]  t;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [7:0]   b [16];
        logic [7:0]   n [16];
        logic [127:0] s;
        for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (i % 8 == 4) begin
                t = subword(t);
            end
            w[i] = w[i-8] ^ t;
        end
        s = pt ^ {w[0], w[1], w[2], w[3]};
        for (int r = 1; r <= 14; r++) begin
            for (int j = 0; j < 16; j++) b[j] = sbox_t[s[127-8*j -: 8]];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) n[q+4*c] = b[q+4*((c+q)%4)];
            b = n;
            if (r < 14) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = n[4*c]; a1 = n[4*c+1]; a2 = n[4*c+2]; a3 = n[4*c+3];
                    b[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    b[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    b[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    b[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int j = 0; j < 16; j++) s[127-8*j -: 8] = b[j];
            s = s ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return s;
    endfunction

    function automatic logic [127:0] gf_mult(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] z, v;
        z = '0;
        v = y;
        for (int i = 0; i < 128; i++) begin
            if (x[127-i]) z = z ^ v;
            v = v[0] ? ((v >> 1) ^ {8'he1, 120'h0}) : (v >> 1);
        end
        return z;
    endfunction

    // Software GCM over blk[]: AAD in blk[0..na-1], text in blk[na..na+nt-1].
    task automatic gcm_ref(input logic dec, input logic [95:0] nv, input int na, input int nt);
        logic [127:0] h, j0, ctr, y, o, c;
        logic [63:0]  la, lt;
        h  = aes_encr(key, 128'h0);
        j0 = {nv, 32'd1};
        y  = '0;
        for (int i = 0; i < na; i++) y = gf_mult(y ^ blk[i], h);
        ctr = j0;
        for (int i = 0; i < nt; i++) begin
            ctr[31:0]  = ctr[31:0] + 32'd1;
            o          = blk[na+i] ^ aes_encr(key, ctr);
            exp_out[i] = o;
            c          = dec ? blk[na+i] : o;
            y          = gf_mult(y ^ c, h);
        end
        la = 64'(na) * 64'd128;
        lt = 64'(nt) * 64'd128;
        y  = gf_mult(y ^ {la, lt}, h);
        exp_tag = y ^ aes_encr(key, j0);
    endtask

    // ---------------- background processes ----------------
    logic [127:0] r_in;
    int           r_dly;
    logic         r_abort;
    initial begin
        resp_ack = 1'b0;
        resp_out = '0;
        forever begin
            @(posedge clk); #1;
            if (aes_req && !rst) begin
                r_in = aes_in;
                req_log.push_back(r_in);
                r_dly   = fixed_dly ? 20 : int'($urandom_range(1, 20));
                r_abort = 1'b0;
                for (int d = 1; d < r_dly; d++) begin
                    @(posedge clk); #1;
                    if (rst) begin
                        r_abort = 1'b1;
                        break;
                    end
                end
                if (!r_abort) begin
                    resp_out = aes_encr(key, r_in);
                    resp_ack = 1'b1;
                    @(posedge clk); #1;
                    resp_ack = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (dout_valid && dout_ready && !rst) out_q.push_back(dout_data);
        end
    end

    initial begin
        dout_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            dout_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_din(input int n, input logic gaps);
        int i, cyc;
        i = 0;
        cyc = 0;
        while (i < n && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (gaps && $urandom_range(0, 3) == 0) din_valid = 1'b0;
            else begin
                din_valid = 1'b1;
                din_data  = blk[i];
            end
            @(negedge clk);
            if (din_valid && din_ready) i++;
        end
        @(posedge clk); #1;
        din_valid = 1'b0;
        n_vec++;
        if (i != n) begin
            n_err++;
            $display("FAIL din_accepts got=%0d want=%0d", i, n);
        end
    endtask

    task automatic run_msg(input logic dec, input logic [95:0] nv, input int na, input int nt,
                           input logic gaps, output logic [127:0] tag);
        logic got_done;
        req_log.delete();
        out_q.delete();
        tag = 'x;
        @(posedge clk); #1;
        decrypt  = dec;
        nonce    = nv;
        aad_blks = na[15:0];
        txt_blks = nt[15:0];
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got_done = 1'b0;
        fork
            drive_din(na + nt, gaps);
            begin
                for (int c = 0; c < 4000; c++) begin
                    @(negedge clk);
                    if (done) begin
                        got_done = 1'b1;
                        tag = tag_out;
                        break;
                    end
                end
            end
        join
        n_vec++;
        if (!got_done) begin
            n_err++;
            $display("FAIL done_seen got=0 want=1");
        end
    endtask

    task automatic check_idle_outputs(input string tag_name);
        n_vec++;
        if ({busy, done, aes_req, din_ready, dout_valid} !== 5'b0) begin
            n_err++;
            $display("FAIL %s_ctrl got=%b want=00000", tag_name, {busy, done, aes_req, din_ready, dout_valid});
        end
        n_vec++;
        if (tag_out !== 128'h0) begin
            n_err++;
            $display("FAIL %s_tag got=%h want=0", tag_name, tag_out);
        end
        n_vec++;
        if (dout_data !== 128'h0) begin
            n_err++;
            $display("FAIL %s_dout got=%h want=0", tag_name, dout_data);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        din_valid = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        din_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_empty();
        logic [127:0] tag;
        key = '0;
        run_msg(1'b0, 96'h0, 0, 0, 1'b0, tag);
        n_vec++;
        if (req_log.size() != 2) begin
            n_err++;
            $display("FAIL t1_req_count got=%0d want=2", req_log.size());
        end
        n_vec++;
        if (tag !== TAG_TC13) begin
            n_err++;
            $display("FAIL t1_tag got=%h want=%h", tag, TAG_TC13);
        end
    endtask

    task automatic test_one_block(input logic dec, input string nm);
        logic [127:0] tag, want_out;
        key = '0;
        blk[0]   = dec ? C_TC14 : 128'h0;
        want_out = dec ? 128'h0 : C_TC14;
        run_msg(dec, 96'h0, 0, 1, 1'b0, tag);
        n_vec++;
        if (out_q.size() != 1 || out_q[0] !== want_out) begin
            n_err++;
            $display("FAIL %s_dout got=%h (n=%0d) want=%h", nm, out_q.size() > 0 ? out_q[0] : 128'hx,
                     out_q.size(), want_out);
        end
        n_vec++;
        if (tag !== TAG_TC14) begin
            n_err++;
            $display("FAIL %s_tag got=%h want=%h", nm, tag, TAG_TC14);
        end
        n_vec++;
        if (req_log.size() != 3) begin
            n_err++;
            $display("FAIL %s_req_count got=%0d want=3", nm, req_log.size());
        end
    endtask

    task automatic check_model(input string nm, input int nt, input logic [127:0] tag);
        n_vec++;
        if (out_q.size() != nt) begin
            n_err++;
            $display("FAIL %s_out_count got=%0d want=%0d", nm, out_q.size(), nt);
        end
        for (int i = 0; i < nt && i < out_q.size(); i++) begin
            n_vec++;
            if (out_q[i] !== exp_out[i]) begin
                n_err++;
                $display("FAIL %s_dout[%0d] got=%h want=%h", nm, i, out_q[i], exp_out[i]);
            end
        end
        n_vec++;
        if (tag !== exp_tag) begin
            n_err++;
            $display("FAIL %s_tag got=%h want=%h", nm, tag, exp_tag);
        end
    endtask

    task automatic test_stalls();
        logic [127:0] tag;
        logic [95:0]  nv;
        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        nv  = {$urandom, $urandom, $urandom};
        for (int i = 0; i < 5; i++) blk[i] = {$urandom, $urandom, $urandom, $urandom};
        gcm_ref(1'b0, nv, 2, 3);
        stall_en = 1'b1;
        run_msg(1'b0, nv, 2, 3, 1'b1, tag);
        stall_en = 1'b0;
        check_model("t4", 3, tag);
    endtask

    task automatic test_ctr_seq();
        logic [127:0] tag, w;
        logic [95:0]  nv;
        nv = {$urandom, $urandom, $urandom};
        for (int i = 0; i < 4; i++) blk[i] = {$urandom, $urandom, $urandom, $urandom};
        gcm_ref(1'b1, nv, 0, 4);
        run_msg(1'b1, nv, 0, 4, 1'b0, tag);
        check_model("t5", 4, tag);
        n_vec++;
        if (req_log.size() != 6 || req_log[0] !== 128'h0) begin
            n_err++;
            $display("FAIL t5_req_head got n=%0d first=%h want n=6 first=0", req_log.size(),
                     req_log.size() > 0 ? req_log[0] : 128'hx);
        end
        for (int i = 1; i < 6 && i < req_log.size(); i++) begin
            n_vec++;
            if (req_log[i] !== {nv, 32'(i)}) begin
                n_err++;
                $display("FAIL t5_aes_in[%0d] got=%h want=%h", i, req_log[i], {nv, 32'(i)});
            end
        end
        w = {nv, 32'hFFFF_FFFF};
        n_vec++;
        if (aes_gcm_pkg::inc32(w) !== {nv, 32'h0}) begin
            n_err++;
            $display("FAIL t5_inc32_wrap got=%h want=%h", aes_gcm_pkg::inc32(w), {nv, 32'h0});
        end
    endtask

    task automatic test_reset_mid();
        int c;
        key = '0;
        req_log.delete();
        fixed_dly = 1'b1;
        @(posedge clk); #1;
        decrypt = 1'b0; nonce = '0; aad_blks = 16'd0; txt_blks = 16'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0;
        while (req_log.size() < 3 && c < 500) begin
            @(negedge clk);
            c++;
        end
        n_vec++;
        if (req_log.size() != 3 || aes_req !== 1'b1) begin
            n_err++;
            $display("FAIL t6_ctr_req got n=%0d req=%b want n=3 req=1", req_log.size(), aes_req);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("t6_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        fixed_dly = 1'b0;
        inj_out = {$urandom, $urandom, $urandom, $urandom};
        inj_ack = 1'b1;
        @(posedge clk); #1;
        inj_ack = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({aes_req, busy, done} !== 3'b000) begin
            n_err++;
            $display("FAIL t6_late_ack got=%b want=000", {aes_req, busy, done});
        end
        test_one_block(1'b0, "t6_restart");
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b1; start = 1'b0; decrypt = 1'b0; key = '0; nonce = '0;
        aad_blks = '0; txt_blks = '0; din_valid = 1'b0; din_data = '0;
        inj_ack = 1'b0; inj_out = '0; fixed_dly = 1'b0; stall_en = 1'b0;
        build_sbox();
        test_reset();
        test_empty();
        test_one_block(1'b0, "t2");
        test_one_block(1'b1, "t3");
        test_stalls();
        test_ctr_seq();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
